// File: rtl/pow2_shift_divider.sv
// Sequential signed divide-by-2^k: one arithmetic shift per cycle behind valid/ready handshakes.
// Optional build macro POW2_DIV_ROUND_NEAREST_EN selects round-half-up instead of floor.
module pow2_shift_divider #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk_lookup,
    input  logic                   clk_lookup_rst_high,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_dividend,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_quotient
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] acc_shr;
    logic        [CNT_W-1:0]      cnt_q;
    logic        [CNT_W-1:0]      cnt_load;
    logic        [31:0]           shift_ext;
    logic        [DATA_WIDTH-1:0] q_final;
    logic                         accept;
    logic                         last;

    // Shifting past DATA_WIDTH leaves only sign bits, so clamping bounds latency for free.
    assign shift_ext = 32'(in_shift);
    assign cnt_load  = (shift_ext > 32'(DATA_WIDTH)) ? CNT_W'(DATA_WIDTH) : CNT_W'(shift_ext);

    assign acc_shr = acc_q >>> 1;
    assign last    = (cnt_q == CNT_W'(1));
    assign accept  = in_valid && in_ready;

`ifdef POW2_DIV_ROUND_NEAREST_EN
    // The bit shifted out on the final step is the rounding bit.
    assign q_final = acc_shr + {{(DATA_WIDTH-1){1'b0}}, acc_q[0]};
`else
    assign q_final = acc_shr;
`endif

    always_ff @(posedge clk_lookup) begin
        if (clk_lookup_rst_high) state_q <= IDLE;
        else                     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !clk_lookup_rst_high;
                if (in_valid && in_ready)
                    state_d = (cnt_load == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_lookup) begin
        if (clk_lookup_rst_high) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_quotient <= '0;
        end else if (accept) begin
            acc_q <= in_dividend;
            cnt_q <= cnt_load;
            if (cnt_load == '0) out_quotient <= in_dividend;
        end else if (state_q == SHIFT) begin
            acc_q <= acc_shr;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) out_quotient <= q_final;
        end
    end

endmodule

// File: tb/tb_pow2_shift_divider.sv
// Scoreboard bench for pow2_shift_divider (32-bit instance plus a 16-bit instance for clamping).
module tb_pow2_shift_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_dividend = '0, out_quotient;
    logic [4:0]  in_shift = '0;

    logic        v16 = 1'b0, r16, ov16;
    logic [15:0] d16 = '0, q16;
    logic [4:0]  s16 = '0;

    typedef struct { longint q; int due; } exp_t;
    exp_t sb[$];
    logic ov_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pow2_shift_divider u_dut (
        .clk_lookup(clk), .clk_lookup_rst_high(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dividend(in_dividend), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient)
    );

    pow2_shift_divider #(.DATA_WIDTH(16), .SHIFT_WIDTH(5)) u_dut16 (
        .clk_lookup(clk), .clk_lookup_rst_high(rst),
        .in_valid(v16), .in_ready(r16), .in_dividend(d16), .in_shift(s16),
        .out_valid(ov16), .out_ready(1'b1), .out_quotient(q16)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: (x + 2^(k-1)) >>> k when rounding, x >>> k otherwise; k clamped to dw.
    function automatic longint model(input longint x, input int k, input int dw);
        int     kk;
        longint r;
        kk = (k > dw) ? dw : k;
        if (kk == 0) r = x;
        else begin
`ifdef POW2_DIV_ROUND_NEAREST_EN
            r = (x + (longint'(1) <<< (kk - 1))) >>> kk;
`else
            r = x >>> kk;
`endif
        end
        return r & ((longint'(1) <<< dw) - 1);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    chk("latency", cyc, sb[0].due);
                    chk("quotient", out_quotient, sb[0].q);
                end
            end else if (out_valid && sb.size() > 0) begin
                chk("hold", out_quotient, sb[0].q);
            end
            if (out_valid) chk("ready_excl", in_ready, 0);
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            ov_prev = out_valid;
        end
    end

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("timeout_ready", in_ready, 1);
    endtask

    task automatic issue(input logic [31:0] d, input int k, output int t);
        int kk;
        wait_rdy();
        kk = (k > 32) ? 32 : k;
        in_valid    = 1'b1;
        in_dividend = d;
        in_shift    = 5'(k);
        t = cyc;
        sb.push_back('{q: model(longint'($signed(d)), k, 32), due: t + kk + 1});
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_dividend = $urandom;
        in_shift    = 5'($urandom);
    endtask

    task automatic issue16(input logic [15:0] d, input int k);
        int t, n, kk;
        n = 0;
        @(negedge clk);
        while (!r16 && n < 100) begin @(negedge clk); n++; end
        kk = (k > 16) ? 16 : k;
        v16 = 1'b1; d16 = d; s16 = 5'(k);
        t = cyc;
        @(posedge clk); #1;
        v16 = 1'b0; d16 = 16'($urandom); s16 = 5'($urandom);
        n = 0;
        @(negedge clk);
        while (!ov16 && n < 100) begin @(negedge clk); n++; end
        chk("lat16", cyc, t + kk + 1);
        chk("quot16", q16, model(longint'($signed(d)), k, 16));
    endtask

    logic [31:0] dv [4] = '{32'd100, -32'sd100, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    int          kv [4] = '{3, 3, 31, 0};

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", out_quotient, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) issue(dv[i], kv[i], t);

        issue16(16'h8000, 31);
        issue16(16'h1234, 4);

        // Backpressure with a competing request pulsed while DONE
        wait_rdy();
        @(posedge clk); #1 out_ready = 1'b0;
        issue(32'd1000, 5, t);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1; in_dividend = 32'd77; in_shift = 5'd1;
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_handshake_ready", in_ready, 0);
        @(negedge clk);
        chk("bp_ready_rise", in_ready, 1);

        // Reset in flight discards the operation
        issue(32'd12345, 20, t);
        while (cyc < t + 4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_quot", out_quotient, 0);
        repeat (30) @(negedge clk);
        issue(32'd64, 2, t);

        for (int i = 0; i < 8; i++) issue($urandom, int'($urandom_range(0, 31)), t);

        wait_rdy();
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pow2_shift_divider.md
# pow2_shift_divider

Sequential signed divider by a power of two, consuming the rounded shift amount produced by the log2 encoder in the welford extern. It takes a signed dividend and a shift exponent `k`, returns `dividend / 2^k` (rounded to nearest or truncated), and shifts one bit per cycle behind valid/ready handshakes. It sits in the welford datapath between the log2 stage and the mean/variance update registers. `k = 0` is the encoder's "don't divide" code and passes the dividend through.

## Interface
- `DATA_WIDTH`, 32: dividend/quotient width, two's complement.
- `SHIFT_WIDTH`, 5: exponent width; matches the encoder output width.

- `clk_lookup`  in  1  sole clock.
- `clk_lookup_rst_high`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_dividend`  in  DATA_WIDTH  signed dividend.
- `in_shift`  in  SHIFT_WIDTH  unsigned exponent `k`.
- `out_valid`  out  1  quotient available.
- `out_ready`  in  1  consumer takes the quotient.
- `out_quotient`  out  DATA_WIDTH  signed result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: load `acc = in_dividend`, `cnt = min(in_shift, DATA_WIDTH)` and `rnd = 0`.
  - Go to DONE if `cnt == 0`, else to SHIFT.
- SHIFT, once per cycle:
  - `rnd <= acc[0]`.
  - `acc <= acc >>> 1` (arithmetic shift).
  - `cnt <= cnt - 1`.
  - On the cycle that consumes the last count, register `out_quotient` and go to DONE.
- Result:
  - With rounding: `out_quotient = acc_final + rnd`, which equals `(x + 2^(k-1)) >>> k`, i.e. round half toward +inf.
  - Without rounding: `out_quotient = acc_final`.
  - No overflow is possible for `k >= 1`. For `k = 0`, `rnd` is 0.
- Clamping: shifts beyond DATA_WIDTH do not change the result (`acc` is all sign bits and `rnd` equals the sign bit), so clamping bounds latency without affecting the value.
- DONE:
  - `out_valid = 1`; `out_quotient` is held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored until IDLE.
- `in_ready` and `out_valid` are never high together.

## Timing
- Reset values: `in_ready` 0 during reset and 1 in the first cycle after it; `out_valid` 0; `out_quotient` 0; state IDLE; `acc`, `cnt` and `rnd` 0.
- Latency: accept at cycle T gives `out_valid` from cycle T+k'+1, where `k' = min(k, DATA_WIDTH)`.
- Handshake completes at cycle D; `in_ready` rises at D+1. Minimum issue interval is k'+2 cycles.
- Reset asserted in any state: next cycle the block is in IDLE with all outputs at reset values. The in-flight operation is discarded and no `out_valid` is issued for it.
- Inputs are sampled only on the accept edge. Later changes to `in_dividend` or `in_shift` have no effect on the operation in flight.
- Backpressure: `out_quotient` must not change while `out_valid && !out_ready`.

## Configuration
- `POW2_DIV_ROUND_NEAREST_EN` defined: result rounds half toward +inf using the last shifted-out bit. This matches the encoder's round-to-nearest exponent.
- Not defined: pure arithmetic shift, i.e. floor division. `rnd` logic and the adder are removed.
- Latency and handshakes are identical in both builds.

## Test plan
- Positive value: `in_dividend = 100`, `in_shift = 3`, accept at T → `out_valid` at T+4. Result 13 with rounding, 12 without.
- Negative value: `in_dividend = -100`, `in_shift = 3` → result -12 with rounding, -13 without. Also `-1`, `in_shift = 31` → result 0 with rounding, -1 without, `out_valid` at T+32.
- Passthrough: `in_dividend = 0x7FFFFFFF`, `in_shift = 0` → `out_quotient = 0x7FFFFFFF` at T+1 in both builds.
- Clamp, with DATA_WIDTH=16: `in_dividend = 0x8000`, `in_shift = 31` → `out_valid` at T+17. Result 0 with rounding, 0xFFFF without.
- Backpressure: hold `out_ready = 0` for 5 cycles after `out_valid`, and pulse `in_valid` with a new request meanwhile → quotient stable, `in_ready` stays 0, new request not accepted until one cycle after the handshake.
- Reset mid-operation: `in_shift = 20`, assert reset at T+5 for one cycle → IDLE next cycle, `out_valid` never asserted for that request. A following request `64 >>> 2` returns 16.
